// File: rtl/chip_io_bridge.sv
// Pad-level bridge: collects strobed request beats into one wide cache request and
// streams each cache response back out as a fixed-length beat train.
module chip_io_bridge #(
  parameter int IO_W      = 12,
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  localparam int CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IO_W-1:0]   io_in,
  output logic [IO_W-1:0]   io_out,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_rw,
  output logic [CORE_W-1:0] req_core,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [CORE_W-1:0] resp_core,
  input  logic [DATA_W-1:0] resp_data,
  output logic              rx_overflow
);

  localparam int IN_PAY    = IO_W - 1;
  localparam int OUT_PAY   = IO_W - 2;
  localparam int REQ_W     = 1 + CORE_W + ADDR_W + DATA_W;
  localparam int RSP_W     = CORE_W + DATA_W;
  localparam int REQ_BEATS = (REQ_W + IN_PAY - 1) / IN_PAY;
  localparam int RSP_BEATS = (RSP_W + OUT_PAY - 1) / OUT_PAY;
  localparam int RX_TOT    = REQ_BEATS * IN_PAY;
  localparam int TX_TOT    = RSP_BEATS * OUT_PAY;
  localparam int RXC_W     = $clog2(REQ_BEATS + 1);
  localparam int TXC_W     = $clog2(RSP_BEATS + 1);

  typedef enum logic {RX_COLLECT, RX_ISSUE} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t          rx_state, rx_state_nxt;
  tx_state_t          tx_state, tx_state_nxt;
  logic [RXC_W-1:0]   rx_cnt;
  logic [TXC_W-1:0]   tx_cnt;
  logic [RX_TOT-1:0]  rx_asm, rx_asm_nxt;
  logic [REQ_W-1:0]   rx_pkt;
  logic [TX_TOT-1:0]  tx_sh, tx_pkt;
  logic               in_strobe;
  logic               rx_take, rx_last, rx_hs, rx_drop;
  logic               tx_load, tx_shift, tx_done;
  logic               out_valid, rx_busy;

  assign in_strobe = io_in[IO_W-1];

  // New beats enter at the top so that after the last beat, beat 0 sits at the LSBs.
  always_comb begin
    rx_asm_nxt = rx_asm >> IN_PAY;
    rx_asm_nxt[RX_TOT-1 -: IN_PAY] = io_in[IN_PAY-1:0];
  end

  assign rx_pkt = rx_asm_nxt[REQ_W-1:0];

  always_comb begin
    rx_state_nxt = rx_state;
    rx_take      = 1'b0;
    rx_last      = 1'b0;
    rx_hs        = 1'b0;
    rx_drop      = 1'b0;
    case (rx_state)
      RX_COLLECT: begin
        if (in_strobe) begin
          rx_take = 1'b1;
          if (rx_cnt == RXC_W'(REQ_BEATS - 1)) begin
            rx_last      = 1'b1;
            rx_state_nxt = RX_ISSUE;
          end
        end
      end
      RX_ISSUE: begin
        rx_drop = in_strobe;
        if (req_ready) begin
          rx_hs        = 1'b1;
          rx_state_nxt = RX_COLLECT;
        end
      end
      default: rx_state_nxt = RX_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state    <= RX_COLLECT;
      rx_cnt      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_hs)
        rx_cnt <= '0;
      else if (rx_take)
        rx_cnt <= rx_cnt + RXC_W'(1);
      if (rx_drop)
        rx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_take)
      rx_asm <= rx_asm_nxt;
  end

  // Request fields must read as zero out of reset, so they are reset despite being data.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_rw   <= 1'b0;
      req_core <= '0;
      req_addr <= '0;
      req_data <= '0;
    end else if (rx_last) begin
      req_rw   <= rx_pkt[0];
      req_core <= rx_pkt[CORE_W:1];
      req_addr <= rx_pkt[CORE_W+ADDR_W:CORE_W+1];
      req_data <= rx_pkt[REQ_W-1 -: DATA_W];
    end
  end

  assign req_valid = (rx_state == RX_ISSUE);
  assign rx_busy   = (rx_state == RX_ISSUE);

  always_comb begin
    tx_pkt = '0;
    tx_pkt[RSP_W-1:0] = {resp_data, resp_core};
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    tx_done      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (resp_valid && resp_ready) begin
          tx_load      = 1'b1;
          tx_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_shift = 1'b1;
        if (tx_cnt == TXC_W'(RSP_BEATS - 1)) begin
          tx_done      = 1'b1;
          tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // resp_ready is its own flop so that it stays low throughout reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      resp_ready <= 1'b0;
    end else begin
      tx_state   <= tx_state_nxt;
      resp_ready <= (tx_state_nxt == TX_IDLE);
      if (tx_load || tx_done)
        tx_cnt <= '0;
      else if (tx_shift)
        tx_cnt <= tx_cnt + TXC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (tx_load)
      tx_sh <= tx_pkt;
    else if (tx_shift)
      tx_sh <= tx_sh >> OUT_PAY;
  end

  assign out_valid = (tx_state == TX_SEND);
  assign io_out    = {out_valid, rx_busy, (out_valid ? tx_sh[OUT_PAY-1:0] : {OUT_PAY{1'b0}})};

endmodule

// File: doc/chip_io_bridge.md
Name: chip_io_bridge

Overview:
- Parametrised chip-level pin bridge that sits between the narrow chip pads (io_in/io_out) and the multicore cache system's request/response interface.
- Deserialises multi-beat request packets from io_in into one wide cache request, using a valid/ready handshake.
- Serialises cache responses back out on io_out as fixed-length beat trains.
- Successor to the fixed 12-pin pass-through top: pad width, core count, address and data widths are all generic, and the bridge has its own framing, backpressure and error behaviour.

Parameters:
- IO_W, 12, pad width of io_in/io_out (must be >= 4)
- NUM_CORES, 4, number of cores; CORE_W = max(1, clog2(NUM_CORES))
- ADDR_W, 16, request address width
- DATA_W, 32, request/response data width
- Derived: IN_PAY = IO_W-1, OUT_PAY = IO_W-2, REQ_W = 1+CORE_W+ADDR_W+DATA_W, RSP_W = CORE_W+DATA_W, REQ_BEATS = ceil(REQ_W/IN_PAY), RSP_BEATS = ceil(RSP_W/OUT_PAY)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- io_in  in  IO_W  [IO_W-1] = in_strobe; [IN_PAY-1:0] = request beat payload
- io_out  out  IO_W  [IO_W-1] = out_valid; [IO_W-2] = rx_busy; [OUT_PAY-1:0] = response beat payload
- req_valid  out  1  request available to cache system
- req_ready  in  1  cache system accepts request
- req_rw  out  1  1 = write, 0 = read
- req_core  out  CORE_W  requesting core id
- req_addr  out  ADDR_W  address
- req_data  out  DATA_W  write data; don't-care for reads
- resp_valid  in  1  response available
- resp_ready  out  1  bridge accepts response
- resp_core  in  CORE_W  response core id
- resp_data  in  DATA_W  response data
- rx_overflow  out  1  sticky: a beat was dropped

Behaviour:
- Clock and reset: all state is on the rising edge of clock. Reset is synchronous, active-high, and wins over every other event.
- Reset values: io_out = 0, req_valid = 0, req_* = 0, resp_ready = 0, rx_overflow = 0, both FSMs idle, beat counters = 0.
- Reset mid-packet discards any partially collected or partially sent packet.
- Request packet layout: {data, addr, core, rw}, with rw at bit 0.
  - Beat k carries packet bits [k*IN_PAY +: IN_PAY], LSB beat first.
  - Pad bits above REQ_W in the last beat are ignored.
- RX FSM, RX_COLLECT:
  - Each cycle with in_strobe = 1 shifts the payload into the assembly register and increments the beat counter.
  - When the REQ_BEATS-th beat is sampled, go to RX_ISSUE. The request fields are registered.
  - req_valid = 1 starting the next cycle (1-cycle latency after the last beat).
- RX FSM, RX_ISSUE:
  - req_valid and the req_* fields are held stable until req_valid & req_ready.
  - On the handshake: req_valid = 0 the following cycle, counter cleared, return to RX_COLLECT.
  - A new packet's first beat may be accepted in that following cycle.
- rx_busy is registered and equals (state == RX_ISSUE).
  - Any in_strobe sampled while in RX_ISSUE is dropped and sets rx_overflow.
  - This includes the cycle in which req_ready handshakes.
  - rx_overflow clears only on reset.
- resp_ready = 1 only in TX_IDLE. Handshake is resp_valid & resp_ready.
- Response packet layout: {resp_data, resp_core}, with core at the LSBs. It is zero-padded to RSP_BEATS*OUT_PAY bits.
- TX FSM, TX_IDLE: on the handshake, latch the packet and go to TX_SEND.
- TX FSM, TX_SEND:
  - out_valid = 1 for exactly RSP_BEATS consecutive cycles.
  - The first beat appears on the cycle after the handshake, LSB beat first.
  - There is no external backpressure.
  - After the last beat, return to TX_IDLE. resp_ready rises the next cycle, so back-to-back responses have at least 1 idle pad cycle between them.
- io_out payload is all zeros whenever out_valid = 0.
- RX and TX are independent and run concurrently. Simultaneous RX issue and TX send has no interaction.
- Defaults: REQ_W = 51, REQ_BEATS = 5, RSP_W = 34, RSP_BEATS = 4.

Test Plan:
- Reset: hold reset 3 cycles, drive io_in = 0xFFF during reset -> io_out = 0, req_valid = 0, rx_overflow = 0, resp_ready = 0; resp_ready = 1 the cycle after reset deasserts.
- Write request: 5 strobed beats encoding rw=1, core=2, addr=0x1234, data=0xDEADBEEF, with req_ready = 1 -> req_valid high 1 cycle starting the cycle after beat 5, fields exact.
- Backpressure: same packet with req_ready = 0 for 10 cycles -> req_valid and fields stable, rx_busy = 1 on io_out; a strobe in that window -> rx_overflow = 1 and the held request is unchanged.
- Response: resp_core=1, resp_data=0x000003FF -> out_valid for 4 cycles, payloads 0x3FD, 0x003, 0x000, 0x000; resp_ready = 0 during the train.
- Concurrency and gaps:
  - Response train overlapping a request collection -> both complete correctly.
  - Non-contiguous strobe gaps inside a request -> assembled request still exact.
- Mid-operation reset: reset after 3 request beats and after 2 response beats -> all outputs 0; a fresh 5-beat packet afterwards decodes correctly.
